// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/issue controller
package hazard_pkg;

    localparam int              REG_ADDR_W  = 5;
    localparam logic [4:0]      ZERO_REG    = 5'd0;
    localparam int              STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] wsel;
    } sb_slot_t;

endpackage

// File: rtl/hazard_if.sv
// rtl/hazard_if.sv - ID-stage request and issue/halt response bundle
interface hazard_if;
    import hazard_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic                  id_we;
    logic [REG_ADDR_W-1:0] id_wsel;
    logic                  halt_req;
    logic                  issue;
    logic                  stall;
    logic                  bubble;
    logic                  halt_ack;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_we, id_wsel, halt_req,
        input  issue, stall, bubble, halt_ack
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_we, id_wsel, halt_req,
        output issue, stall, bubble, halt_ack
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - DEPTH-slot in-flight write tracker with two match ports
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_v,
    input  logic [REG_ADDR_W-1:0] push_wsel,
    input  logic [REG_ADDR_W-1:0] rd_a,
    input  logic [REG_ADDR_W-1:0] rd_b,
    output logic                  match_a,
    output logic                  match_b,
    output logic                  empty
);

    sb_slot_t [DEPTH-1:0] slot_q;
    sb_slot_t [DEPTH-1:0] slot_d;

    always_comb begin
        slot_d      = slot_q;
        // r0 is hardwired, so writes to it never create a dependency
        slot_d[0].v    = push_v & (push_wsel != ZERO_REG);
        slot_d[0].wsel = push_wsel;
        for (int k = 1; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        empty   = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_q[k].v) begin
                empty = 1'b0;
                if (slot_q[k].wsel == rd_a) match_a = 1'b1;
                if (slot_q[k].wsel == rd_b) match_b = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW stall/bubble and halt/drain controller; HAZARD_STATS_EN adds stall_cycles
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    hazard_if.slave                hif
`ifdef HAZARD_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

    state_e state_q;
    state_e state_d;
    logic   match_rs;
    logic   match_rt;
    logic   sb_empty;
    logic   hazard;
    logic   issue;
    logic   stall;
    logic   bubble;

    hazard_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .push_v    (issue & hif.id_we),
        .push_wsel (hif.id_wsel),
        .rd_a      (hif.id_rs),
        .rd_b      (hif.id_rt),
        .match_a   (match_rs),
        .match_b   (match_rt),
        .empty     (sb_empty)
    );

    assign hazard = hif.id_valid &
                    (((hif.id_rs != ZERO_REG) & match_rs) |
                     (hif.id_uses_rt & (hif.id_rt != ZERO_REG) & match_rt));

    always_comb begin
        issue   = 1'b0;
        stall   = 1'b1;
        bubble  = 1'b1;
        state_d = state_q;
        if (reset) begin
            case (state_q)
                RUN: begin
                    if (hif.halt_req) begin
                        state_d = DRAIN;
                    end else begin
                        issue  = hif.id_valid & ~hazard;
                        stall  = hif.id_valid & hazard;
                        bubble = ~(hif.id_valid & ~hazard);
                    end
                end
                DRAIN: begin
                    if (sb_empty) state_d = HALTED;
                end
                HALTED: begin
                    if (!hif.halt_req) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign hif.issue    = issue;
    assign hif.stall    = stall;
    assign hif.bubble   = bubble;
    assign hif.halt_ack = reset & (state_q == HALTED);

`ifdef HAZARD_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    // A halt request in the same cycle takes precedence, so that stall is not counted
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == RUN) && !hif.halt_req && hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against a register-timestamp model
module tb_hazard_ctrl;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_if hif();
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles;
`endif

    hazard_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .hif          (hif)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    typedef struct packed {
        logic        issue;
        logic        stall;
        logic        bubble;
        logic        halt_ack;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: cycle in which each register was last written by an issued instruction
    int cyc = 0;
    int last_wr[32];
    int mode = 0;     // 0 running, 1 draining, 2 halted
    int m_cnt = 0;

    function automatic bit busy(input logic [4:0] r);
        int age;
        age = cyc - last_wr[r];
        return (r != 5'd0) && (age >= 1) && (age <= DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ut, input logic we, input logic [4:0] ws,
                        input logic h, input logic rst, output logic iss);
        exp_t e;
        bit   haz;
        bit   any_busy;
        @(posedge clk);
        #1;
        hif.id_valid   = v;
        hif.id_rs      = rs;
        hif.id_rt      = rt;
        hif.id_uses_rt = ut;
        hif.id_we      = we;
        hif.id_wsel    = ws;
        hif.halt_req   = h;
        reset          = rst;

        any_busy = 1'b0;
        for (int r = 1; r < 32; r++) if (busy(5'(r))) any_busy = 1'b1;
        haz = v && (busy(rs) || (ut && busy(rt)));

        e.issue = 1'b0; e.stall = 1'b1; e.bubble = 1'b1; e.halt_ack = 1'b0;
        e.cnt = 16'(m_cnt);
        if (rst) begin
            if (mode == 2) e.halt_ack = 1'b1;
            if (mode == 0 && !h) begin
                e.issue  = v && !haz;
                e.stall  = v && haz;
                e.bubble = !(v && !haz);
            end
        end
        exp_q.push_back(e);
        iss = e.issue;

        if (!rst) begin
            for (int r = 0; r < 32; r++) last_wr[r] = -1000;
            mode  = 0;
            m_cnt = 0;
        end else begin
            if (e.issue && we && ws != 5'd0) last_wr[ws] = cyc;
            if (mode == 0 && !h && haz && m_cnt < 65535) m_cnt++;
            case (mode)
                0: if (h) mode = 1;
                1: if (!any_busy) mode = 2;
                default: if (!h) mode = 0;
            endcase
        end
        cyc++;
    endtask

    // Present the same ID instruction until the model says it issued
    task automatic hold(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                        input logic we, input logic [4:0] ws, input logic h);
        logic iss;
        int   n;
        n = 0;
        iss = 1'b0;
        while (!iss && n < 20) begin
            step(1'b1, rs, rt, ut, we, ws, h, 1'b1, iss);
            n++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue",    32'(hif.issue),    32'(e.issue));
            chk("stall",    32'(hif.stall),    32'(e.stall));
            chk("bubble",   32'(hif.bubble),   32'(e.bubble));
            chk("halt_ack", 32'(hif.halt_ack), 32'(e.halt_ack));
`ifdef HAZARD_STATS_EN
            chk("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic iss;
        bit   h_rand;
        for (int r = 0; r < 32; r++) last_wr[r] = -1000;
        hif.id_valid = 0; hif.id_rs = 0; hif.id_rt = 0; hif.id_uses_rt = 0;
        hif.id_we = 0; hif.id_wsel = 0; hif.halt_req = 0;
        repeat (2) @(posedge clk);

        step(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, iss);

        // RAW on rs
        step(1, 5'd1, 5'd2, 0, 1, 5'd3, 0, 1, iss);
        hold(5'd3, 5'd0, 0, 0, 5'd0, 0);

        // r0 and rt masking
        step(1, 5'd1, 5'd2, 0, 1, 5'd0, 0, 1, iss);
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, iss);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, iss);
        step(1, 5'd1, 5'd2, 0, 1, 5'd5, 0, 1, iss);
        step(1, 5'd0, 5'd5, 0, 0, 5'd0, 0, 1, iss);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, iss);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, iss);
        step(1, 5'd1, 5'd2, 0, 1, 5'd5, 0, 1, iss);
        hold(5'd0, 5'd5, 1, 0, 5'd0, 0);

        // halt drain with a producer in flight, then release
        step(1, 5'd1, 5'd2, 0, 1, 5'd6, 0, 1, iss);
        repeat (6) step(1, 5'd6, 5'd0, 0, 0, 5'd0, 1, 1, iss);
        hold(5'd9, 5'd0, 0, 0, 5'd0, 0);

        // halt with an empty scoreboard
        repeat (4) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, iss);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, iss);

        // reset mid-stall
        step(1, 5'd1, 5'd2, 0, 1, 5'd7, 0, 1, iss);
        step(1, 5'd7, 5'd0, 0, 0, 5'd0, 0, 1, iss);
        step(1, 5'd7, 5'd0, 0, 0, 5'd0, 0, 0, iss);
        step(1, 5'd7, 5'd0, 0, 0, 5'd0, 0, 1, iss);

        // back-to-back independent
        for (int i = 0; i < 8; i++)
            step(1, 5'(8 + i), 5'(16 + i), 1, 1, 5'(24 + i), 0, 1, iss);

        // randomized traffic, small register range to provoke hazards
        h_rand = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) h_rand = !h_rand;
            step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), h_rand,
                 ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, iss);
        end

        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, iss);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
